// File: rtl/mem_pkg.sv
// Operator codes, FSM states and lane helpers for the memory-access stage.
package mem_pkg;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_t op_size(input logic [7:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB})
            return SIZE_BYTE;
        else if (op inside {OP_LH, OP_LHU, OP_SH})
            return SIZE_HALF;
        else
            return SIZE_WORD;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [7:0] op, input logic [1:0] a);
        case (op_size(op))
            SIZE_BYTE: return 4'b0001 << a;
            SIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [7:0] op, input logic [31:0] d);
        case (op_size(op))
            SIZE_BYTE: return {4{d[7:0]}};
            SIZE_HALF: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op_size(op))
            SIZE_HALF: return a[0];
            SIZE_WORD: return a != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [7:0]  operator,
    input  logic [1:0]  a,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = read_data[7:0];
        case (a)
            2'd1:    sel_byte = read_data[15:8];
            2'd2:    sel_byte = read_data[23:16];
            2'd3:    sel_byte = read_data[31:24];
            default: sel_byte = read_data[7:0];
        endcase
        // Halfword selection deliberately ignores a[0].
        sel_half = a[1] ? read_data[31:16] : read_data[15:0];

        result = read_data;
        case (operator)
            OP_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  result = {24'd0, sel_byte};
            OP_LH:   result = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  result = {16'd0, sel_half};
            default: result = read_data;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// MIPS memory-access stage: request/ack data port, byte lanes, registered write-back.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access trapping (address_error, bad_address).
module stage_mem
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [7:0]                ex_operator,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_result_address,
    input  logic                      ex_write_enable,
    output logic                      dmem_request,
    output logic                      dmem_write,
    output logic [DATA_WIDTH-1:0]     dmem_address,
    output logic [3:0]                dmem_byte_enable,
    output logic [DATA_WIDTH-1:0]     dmem_write_data,
    input  logic                      dmem_ack,
    input  logic [DATA_WIDTH-1:0]     dmem_read_data,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_result_address,
    output logic                      wb_write_enable,
    output logic [DATA_WIDTH-1:0]     wb_result
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                      address_error,
    output logic [DATA_WIDTH-1:0]     bad_address
`endif
);

    state_t                    state, state_next;
    logic [7:0]                op_q, op_next;
    logic [1:0]                a_q, a_next;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_next;
    logic                      we_q, we_next;

    logic                      req_next, write_next;
    logic [DATA_WIDTH-1:0]     addr_next, wdata_next;
    logic [3:0]                be_next;
    logic                      wb_valid_next, wb_we_next;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_next;
    logic [DATA_WIDTH-1:0]     wb_result_next;
    logic [DATA_WIDTH-1:0]     load_value;
    logic                      ex_is_mem;
`ifdef MEM_ALIGN_CHECK_EN
    logic                      err_next;
    logic [DATA_WIDTH-1:0]     bad_next;
`endif

    mem_load_align u_load_align (
        .read_data (dmem_read_data),
        .operator  (op_q),
        .a         (a_q),
        .result    (load_value)
    );

    assign ex_ready  = (state == IDLE);
    assign ex_is_mem = is_load(ex_operator) || is_store(ex_operator);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        op_next        = op_q;
        a_next         = a_q;
        dest_next      = dest_q;
        we_next        = we_q;
        req_next       = dmem_request;
        write_next     = dmem_write;
        addr_next      = dmem_address;
        be_next        = dmem_byte_enable;
        wdata_next     = dmem_write_data;
        wb_valid_next  = 1'b0;
        wb_we_next     = 1'b0;
        wb_addr_next   = wb_result_address;
        wb_result_next = wb_result;
`ifdef MEM_ALIGN_CHECK_EN
        err_next       = 1'b0;
        bad_next       = bad_address;
`endif

        case (state)
            IDLE: begin
                if (ex_valid && !ex_is_mem) begin
                    wb_valid_next  = 1'b1;
                    wb_we_next     = ex_write_enable;
                    wb_addr_next   = ex_result_address;
                    wb_result_next = ex_result;
                end else if (ex_valid) begin
`ifdef MEM_ALIGN_CHECK_EN
                    // A trapped access retires immediately without touching memory.
                    if (is_misaligned(ex_operator, ex_result[1:0])) begin
                        wb_valid_next  = 1'b1;
                        wb_addr_next   = ex_result_address;
                        wb_result_next = ex_result;
                        err_next       = 1'b1;
                        bad_next       = ex_result;
                    end else
`endif
                    begin
                        op_next    = ex_operator;
                        a_next     = ex_result[1:0];
                        dest_next  = ex_result_address;
                        we_next    = ex_write_enable;
                        req_next   = 1'b1;
                        write_next = is_store(ex_operator);
                        addr_next  = {ex_result[DATA_WIDTH-1:2], 2'b00};
                        be_next    = lane_enable(ex_operator, ex_result[1:0]);
                        wdata_next = lane_data(ex_operator, ex_store_data);
                        state_next = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (dmem_ack) begin
                    req_next       = 1'b0;
                    wb_valid_next  = 1'b1;
                    wb_addr_next   = dest_q;
                    wb_we_next     = is_load(op_q) && we_q;
                    wb_result_next = is_load(op_q) ? load_value : '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q              <= '0;
            a_q               <= '0;
            dest_q            <= '0;
            we_q              <= 1'b0;
            dmem_request      <= 1'b0;
            dmem_write        <= 1'b0;
            dmem_address      <= '0;
            dmem_byte_enable  <= '0;
            dmem_write_data   <= '0;
            wb_valid          <= 1'b0;
            wb_write_enable   <= 1'b0;
            wb_result_address <= '0;
            wb_result         <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            address_error     <= 1'b0;
            bad_address       <= '0;
`endif
        end else begin
            op_q              <= op_next;
            a_q               <= a_next;
            dest_q            <= dest_next;
            we_q              <= we_next;
            dmem_request      <= req_next;
            dmem_write        <= write_next;
            dmem_address      <= addr_next;
            dmem_byte_enable  <= be_next;
            dmem_write_data   <= wdata_next;
            wb_valid          <= wb_valid_next;
            wb_write_enable   <= wb_we_next;
            wb_result_address <= wb_addr_next;
            wb_result         <= wb_result_next;
`ifdef MEM_ALIGN_CHECK_EN
            address_error     <= err_next;
            bad_address       <= bad_next;
`endif
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem with randomized traffic against a lane/extension reference model.
module tb_stage_mem;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_operator;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_result_address;
    logic        ex_write_enable;
    logic        dmem_request;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_write_data;
    logic        dmem_ack;
    logic [31:0] dmem_read_data;
    logic        wb_valid;
    logic [4:0]  wb_result_address;
    logic        wb_write_enable;
    logic [31:0] wb_result;
`ifdef MEM_ALIGN_CHECK_EN
    logic        address_error;
    logic [31:0] bad_address;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    stage_mem #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_ready          (ex_ready),
        .ex_operator       (ex_operator),
        .ex_result         (ex_result),
        .ex_store_data     (ex_store_data),
        .ex_result_address (ex_result_address),
        .ex_write_enable   (ex_write_enable),
        .dmem_request      (dmem_request),
        .dmem_write        (dmem_write),
        .dmem_address      (dmem_address),
        .dmem_byte_enable  (dmem_byte_enable),
        .dmem_write_data   (dmem_write_data),
        .dmem_ack          (dmem_ack),
        .dmem_read_data    (dmem_read_data),
        .wb_valid          (wb_valid),
        .wb_result_address (wb_result_address),
        .wb_write_enable   (wb_write_enable),
        .wb_result         (wb_result)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .address_error     (address_error),
        .bad_address       (bad_address)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: access size in bytes, derived from the opcode table.
    function automatic int ref_size(input logic [7:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic ref_is_load(input logic [7:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic logic [3:0] ref_be(input logic [7:0] op, input logic [1:0] a);
        int sz = ref_size(op);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] d);
        int sz = ref_size(op);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] rd, input logic [1:0] a);
        logic [31:0] b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        if (op == OP_LB)  return (b >= 32'h80) ? b - 32'h100 : b;
        if (op == OP_LBU) return b;
        if (op == OP_LH)  return (h >= 32'h8000) ? h - 32'h10000 : h;
        if (op == OP_LHU) return h;
        return rd;
    endfunction

    task automatic do_alu(input logic [7:0] op, input logic [31:0] res, input logic [4:0] dst, input logic we);
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL alu ex_ready: got %b expected 1", ex_ready); end
        ex_valid = 1'b1; ex_operator = op; ex_result = res; ex_result_address = dst;
        ex_write_enable = we; ex_store_data = $urandom;
        @(posedge clock); #1;
        ex_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== res) begin errors++; $display("FAIL alu wb_result: got %h expected %h", wb_result, res); end
        checks++; if (wb_result_address !== dst) begin errors++; $display("FAIL alu wb_result_address: got %0d expected %0d", wb_result_address, dst); end
        checks++; if (wb_write_enable !== we) begin errors++; $display("FAIL alu wb_write_enable: got %b expected %b", wb_write_enable, we); end
        checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL alu dmem_request: got %b expected 0", dmem_request); end
    endtask

    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [4:0] dst, input logic we,
                          input int delay, output int ready_low);
        logic        ld;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        ld = ref_is_load(op);
        ebe = ref_be(op, addr[1:0]);
        eaddr = addr & 32'hFFFF_FFFC;
        ready_low = 0;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL mem ex_ready idle: got %b expected 1", ex_ready); end
        ex_valid = 1'b1; ex_operator = op; ex_result = addr; ex_store_data = sdata;
        ex_result_address = dst; ex_write_enable = we;
        @(posedge clock); #1;
        ex_valid = 1'b0; ex_store_data = $urandom;
        if (ex_ready === 1'b0) ready_low++;
        checks++; if (dmem_request !== 1'b1) begin errors++; $display("FAIL mem dmem_request: got %b expected 1", dmem_request); end
        checks++; if (dmem_write !== !ld) begin errors++; $display("FAIL mem dmem_write: got %b expected %b", dmem_write, !ld); end
        checks++; if (dmem_address !== eaddr) begin errors++; $display("FAIL mem dmem_address: got %h expected %h", dmem_address, eaddr); end
        checks++; if (dmem_byte_enable !== ebe) begin errors++; $display("FAIL mem byte_enable op %h a %0d: got %b expected %b", op, addr[1:0], dmem_byte_enable, ebe); end
        if (!ld) begin
            checks++; if (dmem_write_data !== ref_wdata(op, sdata)) begin errors++; $display("FAIL mem write_data: got %h expected %h", dmem_write_data, ref_wdata(op, sdata)); end
        end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mem wb_valid early: got %b expected 0", wb_valid); end
        for (int i = 0; i < delay; i++) begin
            @(posedge clock); #1;
            if (ex_ready === 1'b0) ready_low++;
            checks++; if (dmem_request !== 1'b1 || dmem_address !== eaddr || dmem_byte_enable !== ebe) begin
                errors++; $display("FAIL mem hold: got req %b addr %h be %b expected 1 %h %b", dmem_request, dmem_address, dmem_byte_enable, eaddr, ebe); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mem wb_valid wait: got %b expected 0", wb_valid); end
        end
        dmem_ack = 1'b1; dmem_read_data = rdata;
        @(posedge clock); #1;
        dmem_ack = 1'b0; dmem_read_data = $urandom;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mem wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_write_enable !== (ld & we)) begin errors++; $display("FAIL mem wb_write_enable: got %b expected %b", wb_write_enable, ld & we); end
        checks++; if (wb_result_address !== dst) begin errors++; $display("FAIL mem wb_result_address: got %0d expected %0d", wb_result_address, dst); end
        if (ld) begin
            checks++; if (wb_result !== ref_load(op, rdata, addr[1:0])) begin errors++; $display("FAIL mem load op %h a %0d rd %h: got %h expected %h", op, addr[1:0], rdata, wb_result, ref_load(op, rdata, addr[1:0])); end
        end
        checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL mem request after ack: got %b expected 0", dmem_request); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL mem ex_ready after ack: got %b expected 1", ex_ready); end
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (address_error !== 1'b0) begin errors++; $display("FAIL mem address_error: got %b expected 0", address_error); end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset ex_ready: got %b expected 1", ex_ready); end
        checks++; if ({dmem_request, dmem_write, dmem_address, dmem_byte_enable, dmem_write_data} !== '0) begin
            errors++; $display("FAIL reset dmem: got req %b addr %h be %b wd %h expected zeros", dmem_request, dmem_address, dmem_byte_enable, dmem_write_data); end
        checks++; if ({wb_valid, wb_write_enable, wb_result_address, wb_result} !== '0) begin
            errors++; $display("FAIL reset wb: got v %b we %b a %0d r %h expected zeros", wb_valid, wb_write_enable, wb_result_address, wb_result); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        ex_valid = 1'b0; dmem_ack = 1'b1; dmem_read_data = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle wb_valid: got %b expected 0", wb_valid); end
        checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL idle dmem_request: got %b expected 0", dmem_request); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL idle ex_ready: got %b expected 1", ex_ready); end
    endtask

    task automatic test_alu();
        logic [7:0] op;
        do_alu(8'h0D, 32'h0000_F00D, 5'd5, 1'b1);
        @(posedge clock); #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu pulse: got %b expected 0", wb_valid); end
        for (int i = 0; i < 10; i++) begin
            do op = 8'($urandom); while (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW});
            do_alu(op, $urandom, 5'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_store();
        int low;
        do_mem(OP_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 5'd7, 1'b1, 0, low);
        checks++; if (low !== 1) begin errors++; $display("FAIL store ready_low: got %0d expected 1", low); end
    endtask

    task automatic test_load();
        int low;
        do_mem(OP_LB, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd3, 1'b1, 3, low);
        checks++; if (low !== 4) begin errors++; $display("FAIL load ready_low: got %0d expected 4", low); end
        checks++; if (wb_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL load lb: got %h expected ffffff80", wb_result); end
        do_mem(OP_LBU, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd3, 1'b1, 1, low);
        checks++; if (wb_result !== 32'h0000_0080) begin errors++; $display("FAIL load lbu: got %h expected 00000080", wb_result); end
        do_mem(OP_LH, 32'h0000_0202, 32'h0, 32'h8001_1234, 5'd9, 1'b1, 2, low);
        checks++; if (wb_result !== 32'hFFFF_8001) begin errors++; $display("FAIL load lh: got %h expected ffff8001", wb_result); end
    endtask

    task automatic test_random_mem();
        logic [7:0]  op;
        logic [31:0] addr;
        int low;
        for (int i = 0; i < 40; i++) begin
            op = mem_ops[$urandom_range(7, 0)];
            addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            if (ref_size(op) == 2) addr[0] = 1'b0;
            if (ref_size(op) == 4) addr[1:0] = 2'b00;
`endif
            do_mem(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(3, 0), low);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        do_mem(OP_LW, 32'h0000_0040, 32'h0, 32'h1234_5678, 5'd1, 1'b1, 0, low);
        do_alu(8'h21 ^ 8'h10, 32'hCAFE_0001, 5'd2, 1'b1);
        do_mem(OP_SW, 32'h0000_0044, 32'h89AB_CDEF, 32'h0, 5'd0, 1'b0, 0, low);
        do_mem(OP_LHU, 32'h0000_0046, 32'h0, 32'hF00F_0001, 5'd4, 1'b1, 0, low);
    endtask

    task automatic test_reset_in_wait();
        ex_valid = 1'b1; ex_operator = OP_LW; ex_result = 32'h0000_0300;
        ex_result_address = 5'd6; ex_write_enable = 1'b1;
        @(posedge clock); #1;
        ex_valid = 1'b0;
        checks++; if (dmem_request !== 1'b1) begin errors++; $display("FAIL rstwait request before: got %b expected 1", dmem_request); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL rstwait dmem_request: got %b expected 0", dmem_request); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait wb_valid: got %b expected 0", wb_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstwait ex_ready: got %b expected 1", ex_ready); end
        dmem_ack = 1'b1; dmem_read_data = 32'h5555_AAAA;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait late ack wb_valid: got %b expected 0", wb_valid); end
        checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL rstwait late ack request: got %b expected 0", dmem_request); end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        logic [7:0]  ops  [2] = '{OP_LW, OP_SH};
        logic [31:0] addrs[2] = '{32'h0000_0101, 32'h0000_0203};
        for (int i = 0; i < 2; i++) begin
            ex_valid = 1'b1; ex_operator = ops[i]; ex_result = addrs[i];
            ex_result_address = 5'd8; ex_write_enable = 1'b1;
            @(posedge clock); #1;
            ex_valid = 1'b0;
            checks++; if (dmem_request !== 1'b0) begin errors++; $display("FAIL align request: got %b expected 0", dmem_request); end
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL align wb_valid: got %b expected 1", wb_valid); end
            checks++; if (wb_write_enable !== 1'b0) begin errors++; $display("FAIL align wb_write_enable: got %b expected 0", wb_write_enable); end
            checks++; if (address_error !== 1'b1) begin errors++; $display("FAIL align address_error: got %b expected 1", address_error); end
            checks++; if (bad_address !== addrs[i]) begin errors++; $display("FAIL align bad_address: got %h expected %h", bad_address, addrs[i]); end
            checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL align ex_ready: got %b expected 1", ex_ready); end
            @(posedge clock); #1;
            checks++; if (address_error !== 1'b0) begin errors++; $display("FAIL align pulse: got %b expected 0", address_error); end
            checks++; if (bad_address !== addrs[i]) begin errors++; $display("FAIL align hold: got %h expected %h", bad_address, addrs[i]); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_operator = '0; ex_result = '0; ex_store_data = '0;
        ex_result_address = '0; ex_write_enable = 1'b0; dmem_ack = 1'b0; dmem_read_data = '0;
        test_reset();
        test_idle();
        test_alu();
        test_store();
        test_load();
        test_random_mem();
        test_back_to_back();
        test_reset_in_wait();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage MIPS pipeline.
- Consumes the execute result (ALU value or effective address), operator, store data and destination info.
- Performs loads and stores over a request/acknowledge data-memory port with byte lanes and sign/zero extension.
- Hands a registered result to write-back, and stalls execute while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width; fixed at 32, other values unsupported.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute presents an instruction this cycle
- ex_ready  out  1  stage accepts ex_* this cycle; combinational, = (state==IDLE)
- ex_operator  in  8  operator code; memory codes in package
- ex_result  in  32  ALU result, or effective address for memory ops
- ex_store_data  in  32  rt value for stores
- ex_result_address  in  5  destination register
- ex_write_enable  in  1  destination write request
- dmem_request  out  1  registered access request
- dmem_write  out  1  1=store, 0=load
- dmem_address  out  32  word-aligned address {ex_result[31:2],2'b00}
- dmem_byte_enable  out  4  lane mask, bit i = bits[8i+7:8i]
- dmem_write_data  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; read data valid same cycle
- dmem_read_data  in  32  load data
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_result_address  out  5  destination register
- wb_write_enable  out  1  forced 0 when wb_valid=0
- wb_result  out  32  final value

Behaviour:
- Reset: synchronous, active-high, named reset. Next edge: state IDLE; every registered output, including dmem_*, wb_* and the captured operation, is 0. An access in flight is abandoned; the memory side tolerates request withdrawal.
- FSM states: IDLE, WAIT_ACK.
- IDLE, ex_valid=1, non-memory op: next edge wb_valid=1, wb_result=ex_result, wb_write_enable=ex_write_enable, wb_result_address=ex_result_address. Latency 1 cycle.
- IDLE, ex_valid=1, memory op: capture operator, address low bits, destination and store data. Next edge: dmem_request=1 with all dmem_* fields set, state to WAIT_ACK.
- WAIT_ACK: ex_ready=0, which stalls execute. All dmem_* outputs are held stable.
- WAIT_ACK, dmem_ack=1: next edge dmem_request=0, wb_valid=1, state IDLE.
  - Loads: wb_write_enable = captured write enable; wb_result = formatted load data.
  - Stores: wb_write_enable=0.
- Minimum memory-op latency: capture at N, request at N+1, ack at N+1, wb_valid at N+2, next accept at N+2.
- dmem_ack while in IDLE is ignored.
- ex_valid=0 in IDLE: wb_valid=0 next edge.
- Little-endian lanes; a = address[1:0].
  - Byte ops: enable = 1<<a; store data = {4{store[7:0]}}.
  - Half ops: enable = a[1] ? 4'b1100 : 4'b0011; store data = {2{store[15:0]}}.
  - Word ops: enable = 4'b1111.
- Load format: shift dmem_read_data right by 8·a (half: 16·a[1]), then extend.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- Misalignment with the feature off: half ignores a[0]; word ignores a[1:0].

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds ports address_error (out, 1) and bad_address (out, 32).
  - A half op with a[0]=1, or a word op with a≠0, issues no dmem_request and stays in IDLE.
  - Next edge: wb_valid=1, wb_write_enable=0, address_error=1 for one cycle, bad_address=ex_result.
  - bad_address holds its value until the next error or reset; reset value 0.
- Undefined: the ports do not exist; behaviour is as in Behaviour.

Decomposition:
- Package mem_pkg:
  - OP_LB=8'h20, OP_LH=8'h21, OP_LW=8'h23, OP_LBU=8'h24, OP_LHU=8'h25, OP_SB=8'h28, OP_SH=8'h29, OP_SW=8'h2B.
  - State encoding IDLE=1'b0, WAIT_ACK=1'b1.
  - Helper functions is_load and is_store.
- Sub-module mem_load_align: combinational. Inputs read data, operator and a; output is the 32-bit extended result.

Test Plan:
- ORI result 0x0000_F00D, dest 5, we=1 -> wb_valid pulse next cycle with those values; no dmem_request.
- SB, addr 0x103, data 0xAB, ack same cycle -> dmem_address 0x100, enable 4'b1000, write_data 0xABABABAB; wb_valid with we=0 two cycles after accept.
- LB, addr 0x102, read_data 0x0080_0000, ack after 3 wait cycles -> ex_ready low 4 cycles; wb_result 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- LH, addr 0x202, read_data 0x8001_1234 -> wb_result 0xFFFF_8001; enable 4'b1100.
- reset asserted in WAIT_ACK -> next edge dmem_request=0, wb_valid=0, ex_ready=1; a later dmem_ack is ignored.
- MEM_ALIGN_CHECK_EN: LW at 0x101 -> no request, address_error pulse, bad_address 0x101, wb_write_enable=0.
